// File: rtl/vga_timgen_param.sv
// VGA timing generator: sync/porch/visible regions per axis, shadowed timing, coordinates, frame count, line irq.
// Latency: state advances one slot per tick; de/sync/pos decode from registered state, end pulses qualified by the tick.
// Backpressure: none; pclk_en_i paces the generator and en_i low aborts the frame back to SYNC/0.
module vga_timgen_param #(
  parameter int         TB_WIDTH   = 8,
  parameter int         VB_WIDTH   = 12,
  parameter int         CNT_WIDTH  = 12,
  parameter int         FCNT_WIDTH = 16,
  parameter logic       HSYNC_POL  = 1'b0,
  parameter logic       VSYNC_POL  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  pclk_en_i,
  input  logic [TB_WIDTH-1:0]   hsnsize_i,
  input  logic [TB_WIDTH-1:0]   hbpsize_i,
  input  logic [TB_WIDTH-1:0]   hfpsize_i,
  input  logic [VB_WIDTH-1:0]   hvlen_i,
  input  logic [TB_WIDTH-1:0]   vsnsize_i,
  input  logic [TB_WIDTH-1:0]   vbpsize_i,
  input  logic [TB_WIDTH-1:0]   vfpsize_i,
  input  logic [VB_WIDTH-1:0]   vvlen_i,
  input  logic [CNT_WIDTH-1:0]  irq_line_i,
  output logic [CNT_WIDTH-1:0]  pos_x_o,
  output logic [CNT_WIDTH-1:0]  pos_y_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  hend_o,
  output logic                  vend_o,
  output logic                  de_o,
  output logic                  fstart_o,
  output logic                  line_irq_o,
  output logic [FCNT_WIDTH-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {ST_SYNC, ST_BP, ST_VIS, ST_FP} region_e;

  // All eight timing fields travel together so a frame boundary swaps them atomically.
  typedef struct packed {
    logic [TB_WIDTH-1:0] hsn;
    logic [TB_WIDTH-1:0] hbp;
    logic [TB_WIDTH-1:0] hfp;
    logic [VB_WIDTH-1:0] hvlen;
    logic [TB_WIDTH-1:0] vsn;
    logic [TB_WIDTH-1:0] vbp;
    logic [TB_WIDTH-1:0] vfp;
    logic [VB_WIDTH-1:0] vvlen;
  } tim_t;

  // Last counter value of the current region (region length minus one).
  function automatic logic [CNT_WIDTH-1:0] region_lim(
    input region_e             st,
    input logic [TB_WIDTH-1:0] sn,
    input logic [TB_WIDTH-1:0] bp,
    input logic [VB_WIDTH-1:0] vl,
    input logic [TB_WIDTH-1:0] fp
  );
    case (st)
      ST_SYNC: return CNT_WIDTH'(sn);
      ST_BP:   return CNT_WIDTH'(bp);
      ST_VIS:  return CNT_WIDTH'(vl);
      default: return CNT_WIDTH'(fp);
    endcase
  endfunction

  // Fixed region order SYNC -> BP -> VIS -> FP -> SYNC.
  function automatic region_e region_next(input region_e st);
    case (st)
      ST_SYNC: return ST_BP;
      ST_BP:   return ST_VIS;
      ST_VIS:  return ST_FP;
      default: return ST_SYNC;
    endcase
  endfunction

  logic                  act_q, act_d;
  region_e               h_st_q, h_st_d, v_st_q, v_st_d;
  logic [CNT_WIDTH-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                  fpend_q, fpend_d;
  tim_t                  tim_q, tim_d, tim_in;

  logic                  tick;
  logic [CNT_WIDTH-1:0]  h_lim, v_lim;
  logic                  h_wrap, v_wrap, h_last, v_last;
  logic                  hend, vend;

  // Gather the live timing inputs into one shadow-sized word.
  always_comb begin
    tim_in       = '0;
    tim_in.hsn   = hsnsize_i;
    tim_in.hbp   = hbpsize_i;
    tim_in.hfp   = hfpsize_i;
    tim_in.hvlen = hvlen_i;
    tim_in.vsn   = vsnsize_i;
    tim_in.vbp   = vbpsize_i;
    tim_in.vfp   = vfpsize_i;
    tim_in.vvlen = vvlen_i;
  end

  // Region-end decodes, built only from shadowed timing and registered counters.
  always_comb begin
    tick   = act_q & en_i & pclk_en_i;
    h_lim  = region_lim(h_st_q, tim_q.hsn, tim_q.hbp, tim_q.hvlen, tim_q.hfp);
    v_lim  = region_lim(v_st_q, tim_q.vsn, tim_q.vbp, tim_q.vvlen, tim_q.vfp);
    h_wrap = (h_cnt_q == h_lim);
    v_wrap = (v_cnt_q == v_lim);
    h_last = (h_st_q == ST_FP) & h_wrap;
    v_last = (v_st_q == ST_FP) & v_wrap;
    hend   = tick & h_last;
    vend   = hend & v_last;
  end

  // Next-state: idle pins both axes at SYNC/0; otherwise advance only on a tick.
  always_comb begin
    act_d   = en_i;
    h_st_d  = h_st_q;
    h_cnt_d = h_cnt_q;
    v_st_d  = v_st_q;
    v_cnt_d = v_cnt_q;
    fcnt_d  = fcnt_q + FCNT_WIDTH'(vend);
    fpend_d = fpend_q;
    tim_d   = tim_q;
    if (!act_q) begin
      h_st_d  = ST_SYNC;
      h_cnt_d = '0;
      v_st_d  = ST_SYNC;
      v_cnt_d = '0;
      fpend_d = 1'b1;
      tim_d   = tim_in;
    end else if (tick) begin
      // The tick that consumes a pending start clears it; a frame end re-arms it.
      fpend_d = vend;
      if (h_wrap) begin
        h_cnt_d = '0;
        h_st_d  = region_next(h_st_q);
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      if (h_last) begin
        if (v_wrap) begin
          v_cnt_d = '0;
          v_st_d  = region_next(v_st_q);
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end
      if (vend) begin
        tim_d = tim_in;
      end
    end
  end

  // State registers; reset parks at SYNC/0 and captures the current timing inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q   <= 1'b0;
      h_st_q  <= ST_SYNC;
      h_cnt_q <= '0;
      v_st_q  <= ST_SYNC;
      v_cnt_q <= '0;
      fcnt_q  <= '0;
      fpend_q <= 1'b1;
      tim_q   <= tim_in;
    end else begin
      act_q   <= act_d;
      h_st_q  <= h_st_d;
      h_cnt_q <= h_cnt_d;
      v_st_q  <= v_st_d;
      v_cnt_q <= v_cnt_d;
      fcnt_q  <= fcnt_d;
      fpend_q <= fpend_d;
      tim_q   <= tim_d;
    end
  end

  // Output decode; everything is forced inactive while the generator is idle.
  always_comb begin
    de_o        = act_q & (h_st_q == ST_VIS) & (v_st_q == ST_VIS);
    pos_x_o     = de_o ? h_cnt_q : '0;
    pos_y_o     = de_o ? v_cnt_q : '0;
    hsync_o     = (act_q & (h_st_q == ST_SYNC)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_o     = (act_q & (v_st_q == ST_SYNC)) ? VSYNC_POL : ~VSYNC_POL;
    hend_o      = hend;
    vend_o      = vend;
    fstart_o    = tick & fpend_q;
    line_irq_o  = hend & (v_st_q == ST_VIS) & (v_cnt_q == irq_line_i);
    frame_cnt_o = fcnt_q;
  end

endmodule

// File: tb/tb_vga_timgen_param.sv
// Bench for vga_timgen_param: directed steps, frame-window measurements checked against a queue of expectations.
// Two instances share stimulus: default polarity/16-bit counter, and inverted polarity with a 3-bit counter.
// All waits are bounded; the run ends with a single summary line.
module tb_vga_timgen_param;

  logic        clk = 1'b0;
  logic        rst_i, en_i, pclk_en_i;
  logic [7:0]  hsnsize_i, hbpsize_i, hfpsize_i, vsnsize_i, vbpsize_i, vfpsize_i;
  logic [11:0] hvlen_i, vvlen_i, irq_line_i;

  logic [11:0] pos_x_o, pos_y_o, pos_x_p, pos_y_p;
  logic        hsync_o, vsync_o, hend_o, vend_o, de_o, fstart_o, line_irq_o;
  logic        hsync_p, vsync_p, hend_p, vend_p, de_p, fstart_p, line_irq_p;
  logic [15:0] frame_cnt_o;
  logic [2:0]  frame_cnt_p;

  always #5 clk = ~clk;

  vga_timgen_param u_dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pclk_en_i(pclk_en_i),
    .hsnsize_i(hsnsize_i), .hbpsize_i(hbpsize_i), .hfpsize_i(hfpsize_i), .hvlen_i(hvlen_i),
    .vsnsize_i(vsnsize_i), .vbpsize_i(vbpsize_i), .vfpsize_i(vfpsize_i), .vvlen_i(vvlen_i),
    .irq_line_i(irq_line_i),
    .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .hend_o(hend_o), .vend_o(vend_o), .de_o(de_o), .fstart_o(fstart_o),
    .line_irq_o(line_irq_o), .frame_cnt_o(frame_cnt_o)
  );

  vga_timgen_param #(.FCNT_WIDTH(3), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_pol (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pclk_en_i(pclk_en_i),
    .hsnsize_i(hsnsize_i), .hbpsize_i(hbpsize_i), .hfpsize_i(hfpsize_i), .hvlen_i(hvlen_i),
    .vsnsize_i(vsnsize_i), .vbpsize_i(vbpsize_i), .vfpsize_i(vfpsize_i), .vvlen_i(vvlen_i),
    .irq_line_i(irq_line_i),
    .pos_x_o(pos_x_p), .pos_y_o(pos_y_p), .hsync_o(hsync_p), .vsync_o(vsync_p),
    .hend_o(hend_p), .vend_o(vend_p), .de_o(de_p), .fstart_o(fstart_p),
    .line_irq_o(line_irq_p), .frame_cnt_o(frame_cnt_p)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int vend_total = 0;
  int pmode = 0;
  int pdiv = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t exp_q[$];
  int   m[16];

  // Frame-end pulses seen so far, the independent reference for the frame counters.
  always @(negedge clk) if (vend_o) vend_total <= vend_total + 1;

  // Pixel strobe: every clk in mode 0, every third clk in mode 1.
  initial begin
    pclk_en_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pmode == 0) pclk_en_i = 1'b1;
      else begin
        pdiv = (pdiv + 1) % 3;
        pclk_en_i = (pdiv == 0);
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Expected contents of one frame window, in the same order measure() fills m[].
  task automatic expect_win(input int de, input int hs, input int vs, input int maxx,
                            input int vend_idx, input int fs_idx, input int irq,
                            input int irq_idx, input int sumx, input int sumy);
    push("de_cycles", de);      push("hend_count", 5);     push("vend_count", 1);
    push("fstart_count", 1);    push("hsync_active", hs);  push("vsync_active", vs);
    push("max_x", maxx);        push("max_y", 1);          push("vend_index", vend_idx);
    push("fstart_index", fs_idx); push("irq_count", irq);  push("irq_index", irq_idx);
    push("hsync_pol_active", hs); push("vsync_pol_active", vs);
    push("sum_x", sumx);        push("sum_y", sumy);
  endtask

  task automatic check_win();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() == 0) chk("queue_underflow", i, -1);
      else begin
        e = exp_q.pop_front();
        chk(e.tag, m[i], e.val);
      end
    end
  endtask

  // Sample n consecutive cycles (1-based index) on the falling edge.
  task automatic measure(input int n);
    for (int i = 0; i < 16; i++) m[i] = 0;
    m[8] = -1; m[9] = -1; m[11] = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (de_o) begin
        m[0]++;
        m[14] += int'(pos_x_o);
        m[15] += int'(pos_y_o);
        if (int'(pos_x_o) > m[6]) m[6] = int'(pos_x_o);
        if (int'(pos_y_o) > m[7]) m[7] = int'(pos_y_o);
      end
      if (hend_o) m[1]++;
      if (vend_o) begin m[2]++; m[8] = i; end
      if (fstart_o) begin m[3]++; if (m[9] < 0) m[9] = i; end
      if (!hsync_o) m[4]++;
      if (!vsync_o) m[5]++;
      if (line_irq_o) begin m[10]++; m[11] = i; end
      if (hsync_p) m[12]++;
      if (vsync_p) m[13]++;
    end
  endtask

  task automatic wait_vend();
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (vend_o) seen = 1'b1;
    end
    chk("vend_seen", int'(seen), 1);
  endtask

  initial begin
    int idle_p;
    int k;
    bit seen;
    rst_i = 1'b1; en_i = 1'b1;
    hsnsize_i = 8'd1; hbpsize_i = 8'd1; hfpsize_i = 8'd1; hvlen_i = 12'd3;
    vsnsize_i = 8'd0; vbpsize_i = 8'd0; vfpsize_i = 8'd0; vvlen_i = 12'd1;
    irq_line_i = 12'd1;
    repeat (3) @(negedge clk);

    // Reset state on both instances.
    chk("rst_hsync", int'(hsync_o), 1);
    chk("rst_vsync", int'(vsync_o), 1);
    chk("rst_hsync_pol", int'(hsync_p), 0);
    chk("rst_vsync_pol", int'(vsync_p), 0);
    chk("rst_de", int'(de_o), 0);
    chk("rst_pos_x", int'(pos_x_o), 0);
    chk("rst_fcnt", int'(frame_cnt_o), 0);
    chk("rst_fstart", int'(fstart_o), 0);
    chk("rst_hend", int'(hend_o), 0);

    // Release: act_q rises on the next edge, first tick carries fstart.
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("pre_start_fstart", int'(fstart_o), 0);
    @(negedge clk);
    chk("first_fstart", int'(fstart_o), 1);
    chk("first_hsync", int'(hsync_o), 0);
    wait_vend();

    // Basic 10-clk lines / 50-clk frame, irq on visible line 1 (4th line end).
    expect_win(8, 10, 10, 3, 50, 1, 1, 40, 12, 4);
    measure(50); check_win();

    // Line number beyond the visible area never matches.
    irq_line_i = 12'd5;
    expect_win(8, 10, 10, 3, 50, 1, 0, -1, 12, 4);
    measure(50); check_win();

    // Mid-frame hvlen change: current frame unchanged, next frame has 14-clk lines.
    irq_line_i = 12'd1;
    @(posedge clk); #1 hvlen_i = 12'd7;
    expect_win(8, 10, 10, 3, 50, 1, 1, 40, 12, 4);
    measure(50); check_win();
    expect_win(16, 10, 14, 7, 70, 1, 1, 56, 56, 8);
    measure(70); check_win();

    // Pixel strobe every 3rd clk: all periods x3, pulses stay one clk wide.
    hvlen_i = 12'd3;
    pmode = 1;
    wait_vend();
    expect_win(24, 30, 30, 3, 150, 3, 1, 120, 36, 12);
    measure(150); check_win();

    // Drop enable in the middle of visible line 0.
    pmode = 0;
    wait_vend();
    repeat (25) @(negedge clk);
    chk("pre_drop_de", int'(de_o), 1);
    @(posedge clk); #1 en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("drop_de", int'(de_o), 0);
    chk("drop_pos_x", int'(pos_x_o), 0);
    chk("drop_hsync", int'(hsync_o), 1);
    chk("drop_hsync_pol", int'(hsync_p), 0);
    idle_p = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hend_o || vend_o || fstart_o || de_o) idle_p++;
    end
    chk("idle_pulses", idle_p, 0);
    chk("drop_fcnt", int'(frame_cnt_o), vend_total);
    chk("drop_vend_total", vend_total, 8);

    // Re-enable: restart from SYNC/0 with fstart, then a full-length frame.
    @(posedge clk); #1 en_i = 1'b1;
    @(negedge clk);
    chk("restart_wait_fstart", int'(fstart_o), 0);
    @(negedge clk);
    chk("restart_fstart", int'(fstart_o), 1);
    chk("restart_hsync", int'(hsync_o), 0);
    k = 0; seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      k++;
      if (vend_o) seen = 1'b1;
    end
    chk("restart_len", k, 49);
    @(negedge clk);
    chk("restart_fcnt", int'(frame_cnt_o), vend_total);

    // Narrow counter on the second instance wraps 7 -> 0.
    for (int it = 0; it < 30 && vend_total < 15; it++) begin
      wait_vend();
      @(negedge clk);
    end
    chk("fcnt_p_before_wrap", int'(frame_cnt_p), 7);
    chk("fcnt_before_wrap", int'(frame_cnt_o), 15);
    wait_vend();
    @(negedge clk);
    chk("fcnt_p_wrap", int'(frame_cnt_p), 0);
    chk("fcnt_after_wrap", int'(frame_cnt_o), 16);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
